// File: rtl/exe_issue_sched_if.sv
// Issue-queue / scheduler / EXE handshake bundle.
// master: issue queue + EXE side (drives requests, flush, exe_ready); slave: the scheduler.
interface exe_issue_sched_if #(
    parameter int N_ENT = 8,
    parameter int AGE_W = 6
);
    localparam int IDX_W = $clog2(N_ENT);

    logic [N_ENT-1:0]       req_valid;
    logic [N_ENT*AGE_W-1:0] req_age;
    logic [N_ENT-1:0]       req_long;
    logic                   exe_ready;
    logic                   flush;
    logic [AGE_W-1:0]       flush_age;
    logic                   grant_valid;
    logic [N_ENT-1:0]       grant_oh;
    logic [IDX_W-1:0]       grant_idx;
    logic [AGE_W-1:0]       grant_age;
    logic                   exe_busy;
    logic                   long_done;

    modport master (
        output req_valid, req_age, req_long, exe_ready, flush, flush_age,
        input  grant_valid, grant_oh, grant_idx, grant_age, exe_busy, long_done
    );

    modport slave (
        input  req_valid, req_age, req_long, exe_ready, flush, flush_age,
        output grant_valid, grant_oh, grant_idx, grant_age, exe_busy, long_done
    );
endinterface

// File: rtl/exe_issue_sched.sv
// EXE issue scheduler: grants the oldest ready entry, blocks during long ops,
// aborts/suppresses work younger than a flush. Ports: CLK, RESET (async, low), bus (slave).
module exe_issue_sched #(
    parameter int N_ENT    = 8,
    parameter int AGE_W    = 6,
    parameter int LONG_LAT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    exe_issue_sched_if.slave  bus
);
    localparam int IDX_W = $clog2(N_ENT);
    localparam int CNT_W = $clog2(LONG_LAT + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LONG = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [AGE_W-1:0] long_age;

    logic [N_ENT-1:0] elig;
    logic             any_elig;
    logic [IDX_W-1:0] pick_idx;
    logic [AGE_W-1:0] pick_age;
    logic [AGE_W-1:0] age_i;
    logic             abort;

    // Wrap-safe ordering: a is older than b when (a-b) mod 2^AGE_W has its MSB set.
    function automatic logic older(input logic [AGE_W-1:0] a,
                                   input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = a - b;
        return d[AGE_W-1];
    endfunction

    // Strict "older" keeps the first (lowest) index on equal ages.
    always_comb begin
        elig     = '0;
        any_elig = 1'b0;
        pick_idx = '0;
        pick_age = '0;
        age_i    = '0;
        for (int i = 0; i < N_ENT; i++) begin
            age_i   = bus.req_age[i*AGE_W +: AGE_W];
            elig[i] = bus.req_valid[i] &&
                      !(bus.flush && older(bus.flush_age, age_i));
            if (elig[i] && (!any_elig || older(age_i, pick_age))) begin
                any_elig = 1'b1;
                pick_idx = IDX_W'(i);
                pick_age = age_i;
            end
        end
    end

    assign abort = bus.flush && older(bus.flush_age, long_age);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state           <= IDLE;
            cnt             <= '0;
            long_age        <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_oh    <= '0;
            bus.grant_idx   <= '0;
            bus.grant_age   <= '0;
            bus.exe_busy    <= 1'b0;
            bus.long_done   <= 1'b0;
        end else begin
            bus.grant_valid <= 1'b0;
            bus.grant_oh    <= '0;
            bus.long_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.exe_ready && !bus.flush && any_elig) begin
                        bus.grant_valid <= 1'b1;
                        bus.grant_oh    <= N_ENT'(1) << pick_idx;
                        bus.grant_idx   <= pick_idx;
                        bus.grant_age   <= pick_age;
                        if (bus.req_long[pick_idx]) begin
                            state        <= LONG;
                            cnt          <= CNT_W'(LONG_LAT - 1);
                            long_age     <= pick_age;
                            bus.exe_busy <= 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (abort) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        bus.exe_busy <= 1'b0;
                    end else if (cnt == CNT_W'(1)) begin
                        // Result held in EXE until MEM side can take it.
                        if (bus.exe_ready) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            bus.exe_busy  <= 1'b0;
                            bus.long_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    bus.exe_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
